// File: rtl/sys_array_ctrl.sv
// Sequencer for a convolution array: loads a 3x3 weight set and a SIZExSIZE image,
// then collects the array's (SIZE-2)^2 results into output memory, with abort and result timeout.
module sys_array_ctrl #(
    parameter int SIZE    = 7,
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     w_rd_en,
    output logic [ADDR_W-1:0]        w_addr,
    input  logic signed [15:0]       w_rdata,
    output logic                     i_rd_en,
    output logic [ADDR_W-1:0]        i_addr,
    input  logic signed [15:0]       i_rdata,
    output logic                     w_load,
    output logic signed [15:0]       w_in,
    output logic                     i_load,
    output logic signed [15:0]       i_in,
    input  logic                     res_sig,
    input  logic [15:0]              result,
    output logic                     o_wr_en,
    output logic [ADDR_W-1:0]        o_addr,
    output logic [15:0]              o_wdata,
    output logic [ADDR_W-1:0]        res_cnt
);

    localparam int IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    localparam logic [ADDR_W-1:0] ZERO_A    = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] W_LAST    = ADDR_W'(8);
    localparam logic [ADDR_W-1:0] PIX_LAST  = ADDR_W'(SIZE * SIZE - 1);
    localparam logic [ADDR_W-1:0] RES_MAX   = ADDR_W'((SIZE - 2) * (SIZE - 2));
    localparam logic [ADDR_W-1:0] RES_PRE   = ADDR_W'((SIZE - 2) * (SIZE - 2) - 1);
    localparam logic [IDLE_W-1:0] IDLE_ZERO = {IDLE_W{1'b0}};
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_W   = 3'd1,
        S_LOAD_I   = 3'd2,
        S_WAIT_RES = 3'd3,
        S_FIN      = 3'd4
    } state_t;

    state_t              state_r, state_s;
    logic                start_ok_s, timeout_s, accept_s;
    logic [ADDR_W-1:0]   w_addr_r, i_addr_r, res_cnt_r;
    logic [IDLE_W-1:0]   idle_cnt_r;
    logic                err_r, w_load_r, i_load_r;
    logic signed [15:0]  w_hold_r, i_hold_r;
    logic [15:0]         o_wdata_r;

    // Results past the expected count are dropped so the output buffer never overruns.
    assign accept_s = res_sig && (state_r != S_IDLE) && (res_cnt_r < RES_MAX);

    assign busy    = (state_r != S_IDLE);
    assign done    = (state_r == S_FIN);
    assign err     = err_r;
    assign w_rd_en = (state_r == S_LOAD_W);
    assign i_rd_en = (state_r == S_LOAD_I);
    assign w_addr  = w_addr_r;
    assign i_addr  = i_addr_r;
    assign w_load  = w_load_r;
    assign i_load  = i_load_r;
    assign w_in    = w_load_r ? w_rdata : w_hold_r;
    assign i_in    = i_load_r ? i_rdata : i_hold_r;
    assign o_wr_en = accept_s;
    assign o_addr  = res_cnt_r;
    assign o_wdata = accept_s ? result : o_wdata_r;
    assign res_cnt = res_cnt_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; abort beats start and every in-flight transition
    always_comb begin
        state_s    = state_r;
        start_ok_s = 1'b0;
        timeout_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start && !abort) begin
                    state_s    = S_LOAD_W;
                    start_ok_s = 1'b1;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LOAD_W: begin
                if (abort) begin
                    state_s = S_IDLE;
                end else if (w_addr_r == W_LAST) begin
                    state_s = S_LOAD_I;
                end else begin
                    state_s = S_LOAD_W;
                end
            end
            S_LOAD_I: begin
                if (abort) begin
                    state_s = S_IDLE;
                end else if (i_addr_r == PIX_LAST) begin
                    state_s = S_WAIT_RES;
                end else begin
                    state_s = S_LOAD_I;
                end
            end
            S_WAIT_RES: begin
                if (abort) begin
                    state_s = S_IDLE;
                end else if ((res_cnt_r == RES_MAX) || (accept_s && (res_cnt_r == RES_PRE))) begin
                    state_s = S_FIN;
                end else if (!res_sig && (idle_cnt_r == IDLE_LAST)) begin
                    state_s   = S_FIN;
                    timeout_s = 1'b1;
                end else begin
                    state_s = S_WAIT_RES;
                end
            end
            S_FIN: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Read address counters; they saturate at their last address instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_addr_r <= ZERO_A;
            i_addr_r <= ZERO_A;
        end else if (start_ok_s) begin
            w_addr_r <= ZERO_A;
            i_addr_r <= ZERO_A;
        end else begin
            if ((state_r == S_LOAD_W) && !abort && (w_addr_r != W_LAST)) begin
                w_addr_r <= w_addr_r + ONE_A;
            end else begin
                w_addr_r <= w_addr_r;
            end
            if ((state_r == S_LOAD_I) && !abort && (i_addr_r != PIX_LAST)) begin
                i_addr_r <= i_addr_r + ONE_A;
            end else begin
                i_addr_r <= i_addr_r;
            end
        end
    end

    // Load strobes track read enables by the memory latency; abort kills the pending one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_load_r <= 1'b0;
            i_load_r <= 1'b0;
            w_hold_r <= 16'sd0;
            i_hold_r <= 16'sd0;
        end else begin
            w_load_r <= w_rd_en && !abort;
            i_load_r <= i_rd_en && !abort;
            w_hold_r <= w_in;
            i_hold_r <= i_in;
        end
    end

    // Result capture, output data hold and timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_cnt_r <= ZERO_A;
            o_wdata_r <= 16'd0;
            err_r     <= 1'b0;
        end else begin
            o_wdata_r <= o_wdata;
            if (start_ok_s) begin
                res_cnt_r <= ZERO_A;
            end else if (accept_s) begin
                res_cnt_r <= res_cnt_r + ONE_A;
            end else begin
                res_cnt_r <= res_cnt_r;
            end
            if (start_ok_s) begin
                err_r <= 1'b0;
            end else if (timeout_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    // Idle counter only runs while waiting for results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_r <= IDLE_ZERO;
        end else if ((state_r == S_WAIT_RES) && !abort) begin
            if (res_sig) begin
                idle_cnt_r <= IDLE_ZERO;
            end else if (idle_cnt_r != IDLE_LAST) begin
                idle_cnt_r <= idle_cnt_r + IDLE_ONE;
            end else begin
                idle_cnt_r <= idle_cnt_r;
            end
        end else begin
            idle_cnt_r <= IDLE_ZERO;
        end
    end

endmodule

// File: tb/tb_sys_array_ctrl.sv
// Directed bench for sys_array_ctrl: memory models, bus monitor and hand-computed expectations.
module tb_sys_array_ctrl;

    localparam int SIZE    = 7;
    localparam int ADDR_W  = 12;
    localparam int TIMEOUT = 255;

    logic               clk = 1'b0;
    logic               rst_n, start, abort, res_sig, mon_clr;
    logic               busy, done, err, w_rd_en, i_rd_en, w_load, i_load, o_wr_en;
    logic [ADDR_W-1:0]  w_addr, i_addr, o_addr, res_cnt;
    logic signed [15:0] w_rdata = 16'sd0;
    logic signed [15:0] i_rdata = 16'sd0;
    logic signed [15:0] w_in, i_in;
    logic [15:0]        result, o_wdata;

    int n_chk = 0;
    int n_fail = 0;

    int cyc, wrd_n, ird_n, wl_n, il_n, wr_n, done_n, ovl;
    int bad_wrd, bad_ird, bad_wl, bad_il, bad_wr, last_wrd, first_ird;
    logic signed [15:0] w_in4;

    always #5 clk = ~clk;

    sys_array_ctrl #(.SIZE(SIZE), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .err(err),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rdata(w_rdata),
        .i_rd_en(i_rd_en), .i_addr(i_addr), .i_rdata(i_rdata),
        .w_load(w_load), .w_in(w_in), .i_load(i_load), .i_in(i_in),
        .res_sig(res_sig), .result(result),
        .o_wr_en(o_wr_en), .o_addr(o_addr), .o_wdata(o_wdata), .res_cnt(res_cnt)
    );

    function automatic logic signed [15:0] wmem_f(input int a);
        if (a == 3) return 16'sh7FFF;
        else return 16'sh0100 + 16'(a);
    endfunction

    function automatic logic signed [15:0] imem_f(input int a);
        return 16'sh2000 + 16'(a * 3);
    endfunction

    function automatic logic [15:0] exp_res(input int k);
        return 16'hA000 + 16'(k);
    endfunction

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memories with one cycle read latency
    always @(posedge clk) begin
        if (w_rd_en) w_rdata <= wmem_f(int'(w_addr));
        if (i_rd_en) i_rdata <= imem_f(int'(i_addr));
    end

    // Bus monitor: tallies reads, loads, writes and done pulses of the current job
    always @(negedge clk) begin
        if (mon_clr) begin
            cyc <= 0; wrd_n <= 0; ird_n <= 0; wl_n <= 0; il_n <= 0; wr_n <= 0;
            done_n <= 0; ovl <= 0; bad_wrd <= 0; bad_ird <= 0; bad_wl <= 0;
            bad_il <= 0; bad_wr <= 0; last_wrd <= -10; first_ird <= -1; w_in4 <= 16'sd0;
        end else begin
            cyc <= cyc + 1;
            if (w_rd_en) begin
                if (int'(w_addr) != wrd_n) bad_wrd <= bad_wrd + 1;
                last_wrd <= cyc;
                wrd_n <= wrd_n + 1;
            end
            if (i_rd_en) begin
                if (int'(i_addr) != ird_n) bad_ird <= bad_ird + 1;
                if (ird_n == 0) first_ird <= cyc;
                ird_n <= ird_n + 1;
            end
            if (w_load) begin
                if (w_in !== wmem_f(wl_n)) bad_wl <= bad_wl + 1;
                if (wl_n == 3) w_in4 <= w_in;
                wl_n <= wl_n + 1;
            end
            if (i_load) begin
                if (i_in !== imem_f(il_n)) bad_il <= bad_il + 1;
                il_n <= il_n + 1;
            end
            if (w_load && i_load) ovl <= ovl + 1;
            if (o_wr_en) begin
                if ((int'(o_addr) != wr_n) || (o_wdata !== exp_res(wr_n))) bad_wr <= bad_wr + 1;
                wr_n <= wr_n + 1;
            end
            if (done) done_n <= done_n + 1;
        end
    end

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic start_pulse();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk_val("start_busy_rd", 32'({busy, w_rd_en}), 32'h3);
        chk_val("start_waddr", 32'(w_addr), 32'd0);
    endtask

    task automatic wait_wait_res();
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk); #1;
            if (busy && !w_rd_en && !i_rd_en) seen = 1'b1;
        end
        chk_val("reach_wait_res", 32'(seen), 32'd1);
    endtask

    task automatic wait_idle();
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(posedge clk); #1;
            if (!busy) seen = 1'b1;
        end
        chk_val("return_idle", 32'(seen), 32'd1);
    endtask

    task automatic send_res(input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            res_sig = 1'b1;
            result  = exp_res(k);
            @(posedge clk); #1;
            res_sig = 1'b0;
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        int  n;
        bit  hit;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; res_sig = 1'b0; result = 16'd0; mon_clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_val("rst_ctl", 32'({busy, done, err, w_rd_en, i_rd_en, w_load, i_load, o_wr_en}), 32'd0);
        chk_val("rst_addr", 32'({w_addr, i_addr}), 32'd0);
        chk_val("rst_cnt", 32'({o_addr, res_cnt}), 32'd0);
        chk_val("rst_data", 32'({w_in, i_in}) | 32'(o_wdata), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Full job: 25 results, weight 3 reads 0x7FFF
        clear_mon();
        start_pulse();
        wait_wait_res();
        send_res(25, 1);
        wait_idle();
        chk_val("j1_wload_n", 32'(wl_n), 32'd9);
        chk_val("j1_wbad", 32'(bad_wl + bad_wrd), 32'd0);
        chk_val("j1_w_in4", 32'(w_in4), 32'h7FFF);
        chk_val("j1_iload_n", 32'(il_n), 32'd49);
        chk_val("j1_ibad", 32'(bad_il + bad_ird), 32'd0);
        chk_val("j1_overlap", 32'(ovl), 32'd0);
        chk_val("j1_i_follows_w", 32'(first_ird), 32'(last_wrd + 1));
        chk_val("j1_writes", 32'(wr_n), 32'd25);
        chk_val("j1_wr_bad", 32'(bad_wr), 32'd0);
        chk_val("j1_done_n", 32'(done_n), 32'd1);
        chk_val("j1_res_cnt", 32'(res_cnt), 32'd25);
        chk_val("j1_err", 32'(err), 32'd0);
        chk_val("j1_hold_w", 32'(w_in), 32'h0108);
        chk_val("j1_hold_i", 32'(i_in), 32'(imem_f(48)));
        chk_val("j1_hold_o", 32'(o_wdata), 32'hA018);

        // 27 back-to-back results with a stray start during LOAD_W
        clear_mon();
        start_pulse();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_wait_res();
        send_res(27, 0);
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk_val("j2_writes", 32'(wr_n), 32'd25);
        chk_val("j2_wr_bad", 32'(bad_wr), 32'd0);
        chk_val("j2_res_cnt", 32'(res_cnt), 32'd25);
        chk_val("j2_done_n", 32'(done_n), 32'd1);
        chk_val("j2_wload_n", 32'(wl_n + bad_wrd), 32'd9);

        // Array stalls after 10 results: timeout
        clear_mon();
        start_pulse();
        wait_wait_res();
        send_res(10, 1);
        n = 1;
        hit = 1'b0;
        while (n < 400 && !hit) begin
            @(posedge clk); #1;
            n++;
            if (done) hit = 1'b1;
        end
        chk_val("j3_timeout_cycles", 32'(n), 32'd255);
        chk_val("j3_err", 32'(err), 32'd1);
        chk_val("j3_res_cnt", 32'(res_cnt), 32'd10);
        wait_idle();
        chk_val("j3_err_sticky", 32'(err), 32'd1);
        chk_val("j3_done_n", 32'(done_n), 32'd1);

        // Abort during LOAD_I at i_addr 20, three results taken before it
        clear_mon();
        start_pulse();
        chk_val("j4_err_cleared", 32'(err), 32'd0);
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(posedge clk); #1;
            res_sig = 1'b0;
            if (i_rd_en && (int'(i_addr) >= 10) && (int'(i_addr) <= 12)) begin
                res_sig = 1'b1;
                result  = exp_res(int'(i_addr) - 10);
            end
            if (i_rd_en && (int'(i_addr) == 20)) hit = 1'b1;
        end
        chk_val("j4_reach_addr20", 32'(hit), 32'd1);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        chk_val("j4_abort_ctl", 32'({busy, w_rd_en, i_rd_en, w_load, i_load, o_wr_en}), 32'd0);
        chk_val("j4_res_kept", 32'(res_cnt), 32'd3);
        repeat (5) @(posedge clk);
        #1;
        chk_val("j4_no_done", 32'({done_n, wr_n, bad_wr}), 32'({32'd0, 32'd3, 32'd0}));
        clear_mon();
        start_pulse();
        wait_wait_res();
        send_res(25, 1);
        wait_idle();
        chk_val("j4_rerun_w", 32'({wrd_n, bad_wrd}), 32'({32'd9, 32'd0}));
        chk_val("j4_rerun_done", 32'({done_n, wr_n}), 32'({32'd1, 32'd25}));

        // start with abort in IDLE: dropped
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk_val("j5_abort_wins", 32'({busy, w_rd_en}), 32'd0);
        chk_val("j5_res_cnt", 32'(res_cnt), 32'd25);

        // Reset during WAIT_RES after 5 results; start in WAIT_RES ignored first
        clear_mon();
        start_pulse();
        wait_wait_res();
        send_res(5, 1);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk_val("j6_start_ignored", 32'({busy, res_cnt}), 32'({1'b1, 12'd5}));
        rst_n = 1'b0;
        #1;
        chk_val("j6_rst_ctl", 32'({busy, done, err, w_rd_en, i_rd_en, w_load, i_load, o_wr_en}), 32'd0);
        chk_val("j6_rst_cnt", 32'({o_addr, res_cnt}), 32'd0);
        chk_val("j6_rst_data", 32'({w_in, i_in}) | 32'(o_wdata), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        clear_mon();
        repeat (10) @(posedge clk);
        #1;
        chk_val("j6_quiet", 32'(wrd_n + ird_n + done_n + wr_n), 32'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
